// File: rtl/seq_pkg.sv
// Shared definitions for the two-bit sequence controller: codes, FSM encoding
// and the forward/reverse successor function.
package seq_pkg;

    localparam logic [1:0] S00 = 2'b00;
    localparam logic [1:0] S11 = 2'b11;
    localparam logic [1:0] S01 = 2'b01;
    localparam logic [1:0] S10 = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    // Forward: 00->11->01->10->00, reverse: 00->10->01->11->00.
    function automatic logic [1:0] seq_next(input logic [1:0] code, input logic dir);
        logic [1:0] nxt;
        nxt = S00;
        case (code)
            S00:     nxt = dir ? S10 : S11;
            S11:     nxt = dir ? S00 : S01;
            S01:     nxt = dir ? S11 : S10;
            S10:     nxt = dir ? S01 : S00;
            default: nxt = S00;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/seq_ctrl_if.sv
// Control/status bundle between a sequence-controller client and seq_ctrl.
interface seq_ctrl_if #(
    parameter int unsigned LEN_W = 8
) ();
    logic             start;
    logic [LEN_W-1:0] len;
    logic             dir;
    logic             pause;
    logic             abort;
    logic             step;
    logic             FA;
    logic             FB;
    logic             busy;
    logic             done;
    logic             wrap;
    logic [LEN_W-1:0] remaining;

    modport master (
        output start, len, dir, pause, abort, step,
        input  FA, FB, busy, done, wrap, remaining
    );

    modport slave (
        input  start, len, dir, pause, abort, step,
        output FA, FB, busy, done, wrap, remaining
    );
endinterface

// File: rtl/seq_core.sv
// Two-bit sequence register: advances one code per enabled cycle and flags
// the cycle in which the code returns to 00.
module seq_core
    import seq_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_adv,
    input  logic       i_dir,
    output logic [1:0] o_code,
    output logic       o_wrap
);

    logic [1:0] r_code;
    logic       r_wrap;
    logic [1:0] w_next;

    assign w_next = seq_next(r_code, i_dir);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_code <= S00;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= i_adv && (w_next == S00);
            if (i_adv) begin
                r_code <= w_next;
            end
        end
    end

    assign o_code = r_code;
    assign o_wrap = r_wrap;

endmodule

// File: rtl/seq_ctrl.sv
// Run controller for the two-bit sequence: counted or free runs, pause,
// abort and idle single-stepping around one seq_core.
module seq_ctrl
    import seq_pkg::*;
#(
    parameter int unsigned LEN_W = 8
) (
    input  logic     t_clock,
    input  logic     t_reset,
    seq_ctrl_if.slave bus
);

    localparam logic [1:0] IDLE  = 2'(ST_IDLE);
    localparam logic [1:0] RUN   = 2'(ST_RUN);
    localparam logic [1:0] PAUSE = 2'(ST_PAUSE);
    localparam logic [1:0] DONE  = 2'(ST_DONE);

    logic [1:0]       r_state;
    logic [LEN_W-1:0] r_rem;
    logic             r_dir;
    logic             r_busy;
    logic             r_done;

    logic [1:0]       w_state_nxt;
    logic [LEN_W-1:0] w_rem_nxt;
    logic             w_dir_nxt;
    logic             w_adv;
    logic             w_core_dir;
    logic [1:0]       w_code;
    logic             w_wrap;

    // State register.
    always_ff @(posedge t_clock) begin
        if (t_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state; in RUN a zero remaining count marks a free run.
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_dir_nxt   = r_dir;
        w_adv       = 1'b0;
        w_core_dir  = r_dir;
        case (r_state)
            IDLE: begin
                if (!bus.abort) begin
                    if (bus.start) begin
                        w_state_nxt = RUN;
                        w_rem_nxt   = bus.len;
                        w_dir_nxt   = bus.dir;
                    end else if (bus.step) begin
                        w_adv      = 1'b1;
                        w_core_dir = bus.dir;
                    end
                end
            end
            RUN: begin
                if (bus.abort) begin
                    w_state_nxt = IDLE;
                    w_rem_nxt   = '0;
                end else if (bus.pause) begin
                    w_state_nxt = PAUSE;
                end else begin
                    w_adv = 1'b1;
                    if (r_rem != '0) begin
                        w_rem_nxt = r_rem - LEN_W'(1);
                        if (r_rem == LEN_W'(1)) begin
                            w_state_nxt = DONE;
                        end
                    end
                end
            end
            PAUSE: begin
                if (bus.abort) begin
                    w_state_nxt = IDLE;
                    w_rem_nxt   = '0;
                end else if (!bus.pause) begin
                    w_state_nxt = RUN;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_rem_nxt   = '0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_rem_nxt   = '0;
            end
        endcase
    end

    // Registered status outputs, derived from the state being entered.
    always_ff @(posedge t_clock) begin
        if (t_reset) begin
            r_rem  <= '0;
            r_dir  <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_rem  <= w_rem_nxt;
            r_dir  <= w_dir_nxt;
            r_busy <= (w_state_nxt == RUN) || (w_state_nxt == PAUSE);
            r_done <= (r_state == RUN) && (w_state_nxt == DONE);
        end
    end

    seq_core u_core (
        .i_clk  (t_clock),
        .i_rst  (t_reset),
        .i_adv  (w_adv),
        .i_dir  (w_core_dir),
        .o_code (w_code),
        .o_wrap (w_wrap)
    );

    assign bus.FA        = w_code[1];
    assign bus.FB        = w_code[0];
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.wrap      = w_wrap;
    assign bus.remaining = r_rem;

endmodule
